// File: rtl/cache_ctrl.sv
// cache_ctrl: 2-way set-associative write-back, write-allocate cache controller with LRU replacement
module cache_ctrl #(
  parameter int ADDR_W = 10,
  parameter int SET_BITS = 1,
  parameter int WORD_BITS = 2,
  localparam int BLK_W = 32 * (2 ** WORD_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              hit_miss,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_ack
);
  localparam int SETS = 2 ** SET_BITS;
  localparam int OFF = WORD_BITS + 2;
  localparam int TAG_W = ADDR_W - OFF - SET_BITS;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE, RESPOND} state_t;
  state_t state, state_nx;
  logic                 req_rw;
  logic [ADDR_W-1:2]    req_a;
  logic [31:0]          req_wdata;
  logic                 vic;
  logic [SETS-1:0]      valid [2];
  logic [SETS-1:0]      dirty [2];
  logic [SETS-1:0]      lru;
  logic [TAG_W-1:0]     tag_mem [2][SETS];
  logic [BLK_W-1:0]     data_mem [2][SETS];
  logic [TAG_W-1:0]     r_tag;
  logic [SET_BITS-1:0]  r_set;
  logic [WORD_BITS-1:0] r_word;
  logic hit0, hit1, hit, vic_c, acc_way, access, fill, unused_bits;
  assign unused_bits = ^cpu_addr[1:0];
  assign r_tag = req_a[ADDR_W-1 -: TAG_W];
  assign r_set = req_a[OFF +: SET_BITS];
  assign r_word = req_a[2 +: WORD_BITS];
  assign hit0 = valid[0][r_set] && tag_mem[0][r_set] == r_tag;
  assign hit1 = valid[1][r_set] && tag_mem[1][r_set] == r_tag;
  assign hit = hit0 | hit1;
  // Invalid ways are filled first (way 0 before way 1); otherwise replace the LRU way
  assign vic_c = !valid[0][r_set] ? 1'b0 : !valid[1][r_set] ? 1'b1 : lru[r_set];
  assign acc_way = state == LOOKUP ? hit1 : vic;
  assign access = (state == LOOKUP && hit) || state == RESPOND;
  assign fill = state == ALLOCATE && mem_ack;

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // Next-state and output decode; every output is a function of state so reset clears it at once
  always_comb begin
    state_nx = state;
    mem_req = 1'b0;
    mem_rw = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (state)
      IDLE:      state_nx = cpu_req ? LOOKUP : IDLE;
      LOOKUP:    state_nx = hit ? IDLE : dirty[vic_c][r_set] ? WRITEBACK : ALLOCATE;
      WRITEBACK: begin
        mem_req = 1'b1;
        mem_addr = {tag_mem[vic][r_set], r_set, {OFF{1'b0}}};
        mem_wdata = data_mem[vic][r_set];
        state_nx = mem_ack ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE:  begin
        mem_req = 1'b1;
        mem_rw = 1'b1;
        mem_addr = {r_tag, r_set, {OFF{1'b0}}};
        state_nx = mem_ack ? RESPOND : ALLOCATE;
      end
      RESPOND:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    cpu_ready = access;
    hit_miss = state == LOOKUP && hit;
    cpu_rdata = (access && req_rw) ? data_mem[acc_way][r_set][{r_word, 5'b0} +: 32] : '0;
  end

  // Capture the request on acceptance and the victim way at lookup
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_rw <= 1'b0;
      req_a <= '0;
      req_wdata <= '0;
      vic <= 1'b0;
    end else begin
      if (state == IDLE && cpu_req) begin
        req_rw <= cpu_rw;
        req_a <= cpu_addr[ADDR_W-1:2];
        req_wdata <= cpu_wdata;
      end
      if (state == LOOKUP) vic <= vic_c;
    end

  // Line status and LRU bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru <= '0;
    end else begin
      if (fill) begin
        valid[vic][r_set] <= 1'b1;
        dirty[vic][r_set] <= 1'b0;
      end
      if (access && !req_rw) dirty[acc_way][r_set] <= 1'b1;
      if (access) lru[r_set] <= ~acc_way;
    end

  // Tag and block storage; contents survive reset, validity does not
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[vic][r_set] <= r_tag;
      data_mem[vic][r_set] <= mem_rdata;
    end
    if (access && !req_rw) data_mem[acc_way][r_set][{r_word, 5'b0} +: 32] <= req_wdata;
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl with a behavioural block memory
module tb_cache_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_rw = 1'b0;
  logic [9:0]   cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready, hit_miss, mem_req, mem_rw;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [127:0] mem [64];
  int errors = 0, checks = 0;
  int ack_delay = 0, al_n = 0, wb_n = 0, hold_n = 0, unstable = 0;
  logic [9:0]   last_addr = '0, prev_addr = '0, wb_addr = '0;
  logic         last_rw = 1'b0, prev_rw = 1'b0;
  logic [127:0] wb_data = '0;
  logic [31:0]  rd;
  logic         hm;
  int           lat;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit_miss(hit_miss),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after ack_delay sampled cycles, logs traffic, watches stability
  initial begin
    int cnt;
    logic [9:0] held;
    cnt = 0;
    held = '0;
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++)
        mem[b][32*w +: 32] = 32'hA000_0000 | (32'(b) << 8) | 32'(w);
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        if (cnt == 0) begin
          held = mem_addr;
          hold_n = 0;
        end else if (mem_addr !== held) unstable++;
        hold_n++;
        if (cnt == ack_delay) begin
          prev_rw = last_rw;
          prev_addr = last_addr;
          last_rw = mem_rw;
          last_addr = mem_addr;
          if (mem_rw) begin
            al_n++;
            mem_rdata = mem[mem_addr[9:4]];
          end else begin
            wb_n++;
            wb_addr = mem_addr;
            wb_data = mem_wdata;
            mem[mem_addr[9:4]] = mem_wdata;
          end
          mem_ack = 1'b1;
        end else cnt++;
      end else cnt = 0;
    end
  end

  task automatic access(input logic rw, input logic [9:0] a, input logic [31:0] wd, input bit poke,
                        output logic [31:0] r, output logic h, output int l);
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_rw = rw;
    cpu_addr = a;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_req = 1'b0;
    l = 1;
    while (!cpu_ready && l < 200) begin
      if (poke) begin
        cpu_req = ~cpu_req;
        cpu_rw = 1'b0;
        cpu_addr = 10'h3F0;
        cpu_wdata = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      l++;
    end
    cpu_req = 1'b0;
    check("ready_seen", cpu_ready, 1'b1);
    r = cpu_rdata;
    h = hit_miss;
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp, input logic exp_hit);
    access(1'b1, a, 32'h0, 1'b0, rd, hm, lat);
    check({tag, "_data"}, rd, exp);
    check({tag, "_hit"}, hm, exp_hit);
  endtask

  task automatic wr_chk(input string tag, input logic [9:0] a, input logic [31:0] d, input logic exp_hit);
    access(1'b0, a, d, 1'b0, rd, hm, lat);
    check({tag, "_rdata0"}, rd, 32'h0);
    check({tag, "_hit"}, hm, exp_hit);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int seen, al0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready", cpu_ready, 1'b0);
    check("rst_hit", hit_miss, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_rw", mem_rw, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 10'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    rd_chk("cold", 10'h004, 32'hA000_0001, 1'b0);
    check("cold_alloc_n", al_n, 1);
    check("cold_alloc_addr", last_addr, 10'h000);
    check("cold_wb_n", wb_n, 0);
    rd_chk("rehit", 10'h004, 32'hA000_0001, 1'b1);
    check("rehit_lat", lat, 1);
    wr_chk("wr_hit", 10'h008, 32'hDEAD_BEEF, 1'b1);
    rd_chk("rd_after_wr", 10'h008, 32'hDEAD_BEEF, 1'b1);
    check("no_traffic", al_n + wb_n, 1);

    do_reset();
    rd_chk("lru_a", 10'h000, 32'hA000_0000, 1'b0);
    rd_chk("lru_b", 10'h040, 32'hA000_0400, 1'b0);
    wr_chk("lru_wa", 10'h000, 32'h1111_1111, 1'b1);
    rd_chk("lru_c", 10'h080, 32'hA000_0800, 1'b0);
    check("lru_c_no_wb", wb_n, 0);
    rd_chk("lru_a_hit", 10'h000, 32'h1111_1111, 1'b1);
    rd_chk("lru_b_again", 10'h040, 32'hA000_0400, 1'b0);
    check("lru_b_no_wb", wb_n, 0);
    rd_chk("lru_a_kept", 10'h000, 32'h1111_1111, 1'b1);

    do_reset();
    wr_chk("dirty_wr", 10'h000, 32'h1234_5678, 1'b0);
    rd_chk("dirty_b", 10'h040, 32'hA000_0400, 1'b0);
    rd_chk("dirty_c", 10'h080, 32'hA000_0800, 1'b0);
    check("wb_n", wb_n, 1);
    check("wb_addr", wb_addr, 10'h000);
    check("wb_word0", wb_data[31:0], 32'h1234_5678);
    check("wb_word1", wb_data[63:32], 32'hA000_0001);
    check("wb_first", prev_rw, 1'b0);
    check("wb_first_addr", prev_addr, 10'h000);
    check("then_alloc", last_rw, 1'b1);
    check("then_alloc_addr", last_addr, 10'h080);
    rd_chk("wb_landed", 10'h000, 32'h1234_5678, 1'b0);

    ack_delay = 5;
    al0 = al_n;
    unstable = 0;
    access(1'b1, 10'h104, 32'h0, 1'b1, rd, hm, lat);
    check("slow_data", rd, 32'hA000_1001);
    check("slow_hit", hm, 1'b0);
    check("slow_hold", hold_n, 6);
    check("slow_stable", unstable, 0);
    check("slow_req_drop", mem_req, 1'b0);
    check("slow_one_alloc", al_n - al0, 1);
    check("slow_no_wb", wb_n, 1);
    ack_delay = 0;
    rd_chk("poke_ignored", 10'h3F0, 32'hA000_3F00, 1'b0);

    ack_delay = 20;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_rw = 1'b1;
    cpu_addr = 10'h204;
    @(negedge clk);
    cpu_req = 1'b0;
    seen = 0;
    while (!(mem_req && mem_rw) && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    check("abort_in_alloc", mem_req && mem_rw, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_req", mem_req, 1'b0);
    check("abort_ready", cpu_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ready) seen++;
    end
    check("abort_no_resp", seen, 0);
    ack_delay = 0;
    rd_chk("abort_reread", 10'h204, 32'hA000_2001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
